// File: rtl/dev_bridge.sv
// dev_bridge: CPU data-port bridge to memory-mapped peripherals.
// One access takes three cycles. The states are IDLE (decode), ACCESS
// (device strobe and read capture) and RESP (ready pulse).
// Device IRQ lines are registered into the 6-bit HWInt vector.
// Optional macro DEV_BRIDGE_IRQ_LATCH_EN: hwint becomes sticky pending bits.
// These bits are set on an IRQ rising edge. A write to word 0 of the
// owning device clears them.
module dev_bridge #(
    parameter int          NDEV      = 2,
    parameter logic [31:0] DEV0_BASE = 32'h0000_7F00,
    parameter int          DEV_SPAN  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [31:0]          cpu_addr,
    input  logic [31:0]          cpu_wdata,
    output logic                 cpu_ready,
    output logic [31:0]          cpu_rdata,
    output logic                 cpu_err,
    output logic [1:0]           dev_addr,
    output logic [31:0]          dev_wdata,
    output logic [NDEV-1:0]      dev_we,
    input  logic [32*NDEV-1:0]   dev_rdata,
    input  logic [NDEV-1:0]      dev_irq,
    output logic [5:0]           hwint
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t            state_r;
    logic              we_r;
    logic              err_r;
    logic [2:0]        sel_r;
    logic              cpu_ready_r;
    logic              cpu_err_r;
    logic [31:0]       cpu_rdata_r;
    logic [1:0]        dev_addr_r;
    logic [31:0]       dev_wdata_r;
    logic [NDEV-1:0]   dev_we_r;
    logic [5:0]        hwint_r;

    logic [31:0]       off_s;
    logic              hit_s;
    logic              err_s;
    logic [2:0]        sel_s;
    logic [NDEV-1:0]   strobe_s;
    logic [31:0]       rd_sel_s;
    logic [5:0]        irq_ext_s;

    // Wrap-around offset into the device region; addresses below the
    // base wrap to large values and miss. Three select bits let all six
    // possible windows decode; for NDEV <= 4 the top bit is always 0 on a hit.
    assign off_s     = cpu_addr - DEV0_BASE;
    assign hit_s     = (off_s < 32'(DEV_SPAN * NDEV));
    assign err_s     = (!hit_s) || (cpu_addr[1:0] != 2'b00);
    assign sel_s     = off_s[6:4];
    assign irq_ext_s = 6'(dev_irq);

    // One-hot strobe pattern for the device being decoded this cycle
    always_comb begin
        strobe_s = {NDEV{1'b0}};
        for (int k = 0; k < NDEV; k++) begin
            strobe_s[k] = (sel_s == 3'(k));
        end
    end

    // Read-data mux for the latched device select
    always_comb begin
        rd_sel_s = 32'h0000_0000;
        for (int k = 0; k < NDEV; k++) begin
            rd_sel_s = (sel_r == 3'(k)) ? dev_rdata[32*k +: 32] : rd_sel_s;
        end
    end

    // Access FSM with all CPU/device outputs registered
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            we_r        <= 1'b0;
            err_r       <= 1'b0;
            sel_r       <= 3'd0;
            cpu_ready_r <= 1'b0;
            cpu_err_r   <= 1'b0;
            cpu_rdata_r <= 32'h0000_0000;
            dev_addr_r  <= 2'b00;
            dev_wdata_r <= 32'h0000_0000;
            dev_we_r    <= {NDEV{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cpu_ready_r <= 1'b0;
                    cpu_err_r   <= 1'b0;
                    if (cpu_req) begin
                        we_r        <= cpu_we;
                        err_r       <= err_s;
                        sel_r       <= sel_s;
                        // Device-side outputs are loaded here so they are valid
                        // throughout ACCESS and hold afterwards.
                        dev_addr_r  <= cpu_addr[3:2];
                        dev_wdata_r <= cpu_wdata;
                        dev_we_r    <= (cpu_we && !err_s) ? strobe_s : {NDEV{1'b0}};
                        state_r     <= ST_ACCESS;
                    end else begin
                        dev_we_r    <= {NDEV{1'b0}};
                        state_r     <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    dev_we_r    <= {NDEV{1'b0}};
                    cpu_rdata_r <= (!we_r && !err_r) ? rd_sel_s : 32'h0000_0000;
                    cpu_ready_r <= 1'b1;
                    cpu_err_r   <= err_r;
                    state_r     <= ST_RESP;
                end
                ST_RESP: begin
                    dev_we_r    <= {NDEV{1'b0}};
                    cpu_ready_r <= 1'b0;
                    cpu_err_r   <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    dev_we_r    <= {NDEV{1'b0}};
                    cpu_ready_r <= 1'b0;
                    cpu_err_r   <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DEV_BRIDGE_IRQ_LATCH_EN
    logic [5:0] irq_prev_r;
    logic [5:0] rise_s;
    logic [5:0] clr_s;

    assign rise_s = irq_ext_s & ~irq_prev_r;

    // Pending-bit clear: a successful write to word 0 (Ctrl) of the owning device
    always_comb begin
        clr_s = 6'b00_0000;
        for (int k = 0; k < 6; k++) begin
            clr_s[k] = (state_r == ST_ACCESS) && we_r && !err_r &&
                       (dev_addr_r == 2'b00) && (sel_r == 3'(k));
        end
    end

    // Sticky pending bits; a set and a clear in the same cycle leave the bit set
    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_prev_r <= 6'b00_0000;
            hwint_r    <= 6'b00_0000;
        end else begin
            irq_prev_r <= irq_ext_s;
            hwint_r    <= (hwint_r & ~clr_s) | rise_s;
        end
    end
`else
    // Plain one-cycle registered copy of the device IRQ lines
    always_ff @(posedge clk) begin
        if (!reset) begin
            hwint_r <= 6'b00_0000;
        end else begin
            hwint_r <= irq_ext_s;
        end
    end
`endif

    assign cpu_ready = cpu_ready_r;
    assign cpu_err   = cpu_err_r;
    assign cpu_rdata = cpu_rdata_r;
    assign dev_addr  = dev_addr_r;
    assign dev_wdata = dev_wdata_r;
    assign dev_we    = dev_we_r;
    assign hwint     = hwint_r;

endmodule

// File: tb/tb_dev_bridge.sv
// Self-checking bench for dev_bridge (NDEV = 2). Devices are modelled as
// small register arrays; expectations come from address arithmetic.
module tb_dev_bridge;
    localparam int          NDEV = 2;
    localparam logic [31:0] BASE = 32'h0000_7F00;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_we, cpu_ready, cpu_err;
    logic [31:0]       cpu_addr, cpu_wdata, cpu_rdata, dev_wdata;
    logic [1:0]        dev_addr;
    logic [NDEV-1:0]   dev_we, dev_irq;
    logic [32*NDEV-1:0] dev_rdata;
    logic [5:0]        hwint;
    logic [31:0]       dmem [NDEV][4];

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    assign dev_rdata = {dmem[1][dev_addr], dmem[0][dev_addr]};

    dev_bridge #(.NDEV(NDEV), .DEV0_BASE(BASE), .DEV_SPAN(16)) dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
        .cpu_rdata(cpu_rdata), .cpu_err(cpu_err), .dev_addr(dev_addr),
        .dev_wdata(dev_wdata), .dev_we(dev_we), .dev_rdata(dev_rdata),
        .dev_irq(dev_irq), .hwint(hwint)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem();
        for (int d = 0; d < NDEV; d++)
            for (int w = 0; w < 4; w++)
                dmem[d][w] = $urandom;
    endtask

    // One complete access with checks at ACCESS, RESP and the cycle after
    task automatic do_access(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input string name);
        logic [31:0]     off;
        logic            exp_err;
        int              sel;
        logic [NDEV-1:0] exp_we;
        logic [31:0]     exp_rd;
        off     = addr - BASE;
        exp_err = (off >= 32'd32) || (addr % 4 != 0);
        sel     = int'(off / 32'd16);
        exp_we  = 2'b00;
        exp_rd  = 32'h0;
        if (!exp_err) begin
            if (we) exp_we = 2'b01 << sel;
            else    exp_rd = dmem[sel][addr[3:2]];
        end
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        tick();
        vectors++;
        if (dev_we !== exp_we || dev_addr !== addr[3:2] || dev_wdata !== wdata || cpu_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s access: we=%b addr=%b wdata=%h ready=%b expected we=%b addr=%b wdata=%h ready=0",
                     name, dev_we, dev_addr, dev_wdata, cpu_ready, exp_we, addr[3:2], wdata);
        end
        tick();
        cpu_req = 1'b0;
        vectors++;
        if (cpu_ready !== 1'b1 || cpu_err !== exp_err || cpu_rdata !== exp_rd || dev_we !== 2'b00) begin
            errors++;
            $display("FAIL %s resp: ready=%b err=%b rdata=%h we=%b expected ready=1 err=%b rdata=%h we=00",
                     name, cpu_ready, cpu_err, cpu_rdata, dev_we, exp_err, exp_rd);
        end
        tick();
        vectors++;
        if (cpu_ready !== 1'b0 || dev_we !== 2'b00) begin
            errors++;
            $display("FAIL %s after: ready=%b we=%b expected ready=0 we=00", name, cpu_ready, dev_we);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0;
        cpu_wdata = 32'h0; dev_irq = 2'b00;
        fill_mem();
        repeat (3) tick();
        vectors++;
        if ({cpu_ready, cpu_err, cpu_rdata, dev_we, dev_addr, dev_wdata, hwint} !== '0) begin
            errors++;
            $display("FAIL reset_state: ready=%b err=%b rdata=%h we=%b addr=%b wdata=%h hwint=%b expected all 0",
                     cpu_ready, cpu_err, cpu_rdata, dev_we, dev_addr, dev_wdata, hwint);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_write_hit();
        do_access(1'b1, 32'h0000_7F14, 32'hA5A5_0001, "write_hit");
    endtask

    task automatic test_read_hit();
        dmem[0][2] = 32'h0000_0123;
        do_access(1'b0, 32'h0000_7F08, 32'h0, "read_hit");
    endtask

    task automatic test_errors();
        do_access(1'b0, 32'h0000_7F20, 32'h0, "err_miss_high");
        do_access(1'b1, 32'h0000_7F02, 32'h1234_5678, "err_unaligned");
        do_access(1'b0, 32'h0000_7EFC, 32'h0, "err_below_base");
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            if (i % 8 == 0) fill_mem();
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = BASE - 32'd8 + 32'($urandom_range(0, 47));
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            do_access(1'(($urandom) & 1), a, $urandom, "random");
        end
    endtask

    task automatic test_back_to_back();
        int t1 = -1, t2 = -1, npulse = 0;
        fill_mem();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_7F00;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (cpu_ready === 1'b1) begin
                npulse++;
                if (t1 < 0) begin
                    t1 = c;
                    vectors++;
                    if (cpu_rdata !== dmem[0][0]) begin
                        errors++;
                        $display("FAIL b2b_first rdata: got %h expected %h", cpu_rdata, dmem[0][0]);
                    end
                    cpu_addr = 32'h0000_7F10;
                end else if (t2 < 0) begin
                    t2 = c;
                    vectors++;
                    if (cpu_rdata !== dmem[1][0]) begin
                        errors++;
                        $display("FAIL b2b_second rdata: got %h expected %h", cpu_rdata, dmem[1][0]);
                    end
                    cpu_req = 1'b0;
                end
            end
        end
        cpu_req = 1'b0;
        vectors++;
        if (npulse != 2 || t1 < 0 || t2 < 0 || (t2 - t1) != 3) begin
            errors++;
            $display("FAIL b2b_spacing: pulses=%0d gap=%0d expected pulses=2 gap=3", npulse, t2 - t1);
        end
    endtask

    task automatic test_reset_mid_write();
        int seen = 0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_7F04; cpu_wdata = $urandom;
        tick();
        vectors++;
        if (dev_we !== 2'b01) begin
            errors++;
            $display("FAIL rst_mid_strobe: got %b expected 01", dev_we);
        end
        reset = 1'b0;
        tick();
        cpu_req = 1'b0;
        vectors++;
        if ({cpu_ready, cpu_err, cpu_rdata, dev_we, dev_addr, dev_wdata, hwint} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: ready=%b we=%b addr=%b wdata=%h expected all 0",
                     cpu_ready, dev_we, dev_addr, dev_wdata);
        end
        tick();
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (cpu_ready === 1'b1 || dev_we !== 2'b00) seen++;
        end
        vectors++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_mid_abandon: got %0d cycles with ready/strobe expected 0", seen);
        end
    endtask

    task automatic test_irq();
        logic [1:0] v;
        logic [1:0] pend;
        logic [1:0] prev;
        dev_irq = 2'b00;
        tick();
        dev_irq = 2'b01;
        tick();
        vectors++;
        if (hwint !== 6'b000001) begin
            errors++;
            $display("FAIL irq_first: got %b expected 000001", hwint);
        end
`ifdef DEV_BRIDGE_IRQ_LATCH_EN
        dev_irq = 2'b00;
        repeat (3) tick();
        vectors++;
        if (hwint !== 6'b000001) begin
            errors++;
            $display("FAIL irq_sticky: got %b expected 000001", hwint);
        end
        do_access(1'b1, 32'h0000_7F04, 32'h1, "irq_wr_word1");
        vectors++;
        if (hwint !== 6'b000001) begin
            errors++;
            $display("FAIL irq_word1_noclear: got %b expected 000001", hwint);
        end
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_7F00; cpu_wdata = 32'h0;
        tick();
        vectors++;
        if (hwint !== 6'b000001) begin
            errors++;
            $display("FAIL irq_clear_access: got %b expected 000001", hwint);
        end
        tick();
        cpu_req = 1'b0;
        vectors++;
        if (hwint !== 6'b000000) begin
            errors++;
            $display("FAIL irq_clear: got %b expected 000000", hwint);
        end
        tick();
        cpu_req = 1'b1;
        tick();
        dev_irq = 2'b01;
        tick();
        cpu_req = 1'b0;
        vectors++;
        if (hwint !== 6'b000001) begin
            errors++;
            $display("FAIL irq_set_wins: got %b expected 000001", hwint);
        end
        dev_irq = 2'b00;
        tick();
        pend = 2'b01;
        prev = 2'b00;
        for (int i = 0; i < 20; i++) begin
            v = 2'($urandom);
            pend = pend | (v & ~prev);
            prev = v;
            dev_irq = v;
            tick();
            vectors++;
            if (hwint !== {4'b0000, pend}) begin
                errors++;
                $display("FAIL irq_random_latch: got %b expected %b", hwint, {4'b0000, pend});
            end
        end
`else
        pend = 2'b00;
        prev = 2'b00;
        for (int i = 0; i < 20; i++) begin
            v = 2'($urandom);
            dev_irq = v;
            tick();
            vectors++;
            if (hwint !== {4'b0000, v}) begin
                errors++;
                $display("FAIL irq_random: got %b expected %b", hwint, {4'b0000, v});
            end
        end
        // IRQ sampling is unaffected by an access in flight
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_7F00;
        tick();
        dev_irq = 2'b10;
        tick();
        cpu_req = 1'b0;
        vectors++;
        if (hwint !== 6'b000010) begin
            errors++;
            $display("FAIL irq_during_access: got %b expected 000010", hwint);
        end
        tick();
`endif
        dev_irq = 2'b00;
    endtask

    initial begin
        test_reset();
        test_write_hit();
        test_read_hit();
        test_errors();
        test_random();
        test_back_to_back();
        test_reset_mid_write();
        test_irq();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
